// File: rtl/fir_pkg.sv
// Shared constants, result word type and reference rescale/round/saturate helper for the FIR output stage.
// Build option FIR_OUT_ROUND_EN selects round-half-up instead of floor before the shift.
package fir_pkg;

    localparam int ACC_W      = 41;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 15;
    localparam int FIFO_DEPTH = 4;

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [ACC_W:0] RND_TERM = (ACC_W+1)'(1) << (FRAC_SHIFT-1);
`else
    localparam logic signed [ACC_W:0] RND_TERM = '0;
`endif

    typedef struct packed {
        logic                    sat;
        logic signed [OUT_W-1:0] data;
    } out_word_t;

    function automatic out_word_t sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] q;
        out_word_t             w;
        r = $signed({acc[ACC_W-1], acc}) + RND_TERM;
        q = r >>> FRAC_SHIFT;
        if (q > $signed({{(ACC_W+1-OUT_W){1'b0}}, SAT_MAX})) begin
            w.sat  = 1'b1;
            w.data = SAT_MAX;
        end else if (q < $signed({{(ACC_W+1-OUT_W){1'b1}}, SAT_MIN})) begin
            w.sat  = 1'b1;
            w.data = SAT_MIN;
        end else begin
            w.sat  = 1'b0;
            w.data = q[OUT_W-1:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO: head is read combinationally from storage, with occupancy count.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module fir_out_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        dropped  = push & ~push_ok;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fir_out_formatter.sv
// FIR output formatter: edge-captures the accumulator, rescales/rounds/saturates to OUT_W, buffers in a FIFO.
// Build option FIR_OUT_ROUND_EN adds 2^(FRAC_SHIFT-1) before the shift; otherwise the shift floors.
module fir_out_formatter #(
    parameter int ACC_W      = fir_pkg::ACC_W,
    parameter int OUT_W      = fir_pkg::OUT_W,
    parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
    parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_W-1:0]              acc_in,
    input  logic                          acc_valid,
    output logic [OUT_W-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          sat_flag,
    output logic                          drop_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int RW = ACC_W + 1;

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [RW-1:0] Q_MAX = {{(RW-OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [RW-1:0] Q_MIN = {{(RW-OUT_W){1'b1}}, OUT_MIN};

`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [RW-1:0] RND = RW'(1) << (FRAC_SHIFT-1);
`else
    localparam logic signed [RW-1:0] RND = '0;
`endif

    logic               acc_valid_q, acc_valid_d;
    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic [ACC_W-1:0]   acc_r_q, acc_r_d;
    logic [OUT_W:0]     word_q, word_d;
    logic               drop_flag_q, drop_flag_d;
    logic               cap;

    logic signed [RW-1:0] r_w;
    logic signed [RW-1:0] q_w;
    logic [OUT_W-1:0]     data_w;
    logic                 sat_w;

    logic [OUT_W:0]       head;
    logic                 fifo_full, fifo_empty, fifo_drop;

    // Stage 2 arithmetic: sign-extend one bit so the rounding add cannot overflow.
    always_comb begin
        r_w    = $signed({acc_r_q[ACC_W-1], acc_r_q}) + RND;
        q_w    = r_w >>> FRAC_SHIFT;
        sat_w  = 1'b0;
        data_w = q_w[OUT_W-1:0];
        if (q_w > Q_MAX) begin
            sat_w  = 1'b1;
            data_w = OUT_MAX;
        end else if (q_w < Q_MIN) begin
            sat_w  = 1'b1;
            data_w = OUT_MIN;
        end
    end

    always_comb begin
        cap         = acc_valid & ~acc_valid_q;
        acc_valid_d = acc_valid;
        v1_d        = cap;
        acc_r_d     = cap ? acc_in : acc_r_q;
        v2_d        = v1_q;
        word_d      = v1_q ? {sat_w, data_w} : word_q;
        drop_flag_d = drop_flag_q | fifo_drop;
    end

    // acc_valid_q resets high so a level already asserted at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid_q <= 1'b1;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            acc_r_q     <= '0;
            word_q      <= '0;
            drop_flag_q <= 1'b0;
        end else begin
            acc_valid_q <= acc_valid_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            acc_r_q     <= acc_r_d;
            word_q      <= word_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    fir_out_fifo #(
        .DW    (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (v2_q),
        .wdata   (word_q),
        .pop     (dout_ready),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_drop),
        .count   (fifo_level)
    );

    always_comb begin
        dout_valid = ~fifo_empty;
        dout       = fifo_empty ? '0 : head[OUT_W-1:0];
        sat_flag   = fifo_empty ? 1'b0 : head[OUT_W];
        drop_flag  = drop_flag_q;
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_fir_out_formatter.sv
// Directed bench for fir_out_formatter with a scoreboard of expected FIFO outputs checked on every pop.
module tb_fir_out_formatter;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [40:0] acc_in = '0;
    logic        acc_valid = 1'b0;
    logic        dout_ready = 1'b1;
    logic [15:0] dout;
    logic        dout_valid;
    logic        sat_flag;
    logic        drop_flag;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;
    out_word_t sb_q[$];

    fir_out_formatter dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_flag   (sat_flag),
        .drop_flag  (drop_flag),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic out_word_t mk(input logic s, input logic [15:0] d);
        out_word_t w;
        w.sat  = s;
        w.data = d;
        return w;
    endfunction

    // Independent reference: 64-bit integer arithmetic, then clamp.
    function automatic out_word_t model(input longint acc);
        longint r;
        longint q;
`ifdef FIR_OUT_ROUND_EN
        r = acc + 64'sd16384;
`else
        r = acc;
`endif
        q = r >>> 15;
        if (q > 64'sd32767)       return mk(1'b1, 16'h7FFF);
        else if (q < -64'sd32768) return mk(1'b1, 16'h8000);
        else                      return mk(1'b0, q[15:0]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input longint v);
        acc_in    = v[40:0];
        acc_valid = 1'b1;
        tick(1);
        acc_valid = 1'b0;
        tick(1);
    endtask

    task automatic send(input longint v, input out_word_t e);
        sb_q.push_back(e);
        $display("send acc=%0d expect data=0x%04h sat=%0b", v, e.data, e.sat);
        pulse(v);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid && dout_ready) begin
                chk("sb_nonempty_on_pop", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    out_word_t e;
                    e = sb_q.pop_front();
                    $display("pop data=0x%04h sat=%0b (expect 0x%04h sat=%0b)", dout, sat_flag, e.data, e.sat);
                    chk("dout", {16'h0, dout}, {16'h0, e.data});
                    chk("sat_flag", 32'(sat_flag), 32'(e.sat));
                end
            end else if (!dout_valid) begin
                chk("idle_outputs_zero", {15'h0, sat_flag, dout}, 32'd0);
            end
        end
    end

    initial begin
        longint v;
        // Reset state
        tick(3);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_dout", {16'h0, dout}, 0);
        chk("rst_sat_flag", 32'(sat_flag), 0);
        chk("rst_drop_flag", 32'(drop_flag), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        rst = 1'b0;
        tick(1);

        // 1: unity sample and latency (capture edge, +1 not yet valid, +2 valid)
        send(64'sd32768, mk(1'b0, 16'd1));
        chk("lat_not_yet", 32'(dout_valid), 0);
        tick(1);
        chk("lat_valid", 32'(dout_valid), 1);
        chk("lat_dout", {16'h0, dout}, 32'd1);
        tick(2);

        // 2: half-LSB rounding behaviour
`ifdef FIR_OUT_ROUND_EN
        send(64'sd16384, mk(1'b0, 16'd1));
        send(-64'sd16384, mk(1'b0, 16'd0));
`else
        send(64'sd16384, mk(1'b0, 16'd0));
        send(-64'sd16384, mk(1'b0, 16'hFFFF));
`endif

        // 3: saturation and clamp boundaries
        send(64'sd2147483648, mk(1'b1, 16'h7FFF));
        send(-64'sd2147483648, mk(1'b1, 16'h8000));
        send(64'sd32767 <<< 15, mk(1'b0, 16'h7FFF));
        send(64'sd32768 <<< 15, mk(1'b1, 16'h7FFF));
        send(-(64'sd32768 <<< 15), mk(1'b0, 16'h8000));
        send(-(64'sd32769 <<< 15), mk(1'b1, 16'h8000));
        for (int i = 0; i < 6; i++) begin
            v = longint'($signed($urandom)) <<< $urandom_range(0, 9);
            send(v, model(v));
        end
        tick(4);

        // 4: level held high for 5 cycles gives one capture
        dout_ready = 1'b0;
        acc_in     = 41'(64'sd5 <<< 15);
        acc_valid  = 1'b1;
        sb_q.push_back(mk(1'b0, 16'd5));
        tick(5);
        acc_valid = 1'b0;
        tick(3);
        chk("held_level_one", 32'(fifo_level), 1);
        dout_ready = 1'b1;
        tick(2);
        chk("held_drained", 32'(fifo_level), 0);

        // 5: overflow with ready low, fifth sample dropped
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb_q.push_back(mk(1'b0, 16'(k)));
            $display("send acc=%0d (k=%0d)", k <<< 15, k);
            pulse(longint'(k) <<< 15);
        end
        tick(2);
        chk("full_level", 32'(fifo_level), 4);
        chk("drop_set", 32'(drop_flag), 1);
        dout_ready = 1'b1;
        tick(6);
        chk("drain_level", 32'(fifo_level), 0);
        chk("drop_sticky", 32'(drop_flag), 1);
        chk("drain_sb_empty", 32'(sb_q.size()), 0);

        // 6a: acc_valid high across reset release gives no capture
        acc_in    = 41'(64'sd7 <<< 15);
        acc_valid = 1'b1;
        rst       = 1'b1;
        tick(2);
        chk("rst_clears_drop", 32'(drop_flag), 0);
        rst = 1'b0;
        tick(4);
        chk("no_capture_after_rst", 32'(fifo_level), 0);
        acc_valid = 1'b0;
        tick(1);
        sb_q.push_back(mk(1'b0, 16'd7));
        acc_valid = 1'b1;
        tick(1);
        acc_valid = 1'b0;
        tick(4);
        chk("recapture_sb_empty", 32'(sb_q.size()), 0);

        // 6b: full FIFO with simultaneous pop and push
        dout_ready = 1'b0;
        for (int k = 10; k <= 13; k++) send(longint'(k) <<< 15, mk(1'b0, 16'(k)));
        tick(2);
        chk("pre_full_level", 32'(fifo_level), 4);
        sb_q.push_back(mk(1'b0, 16'd14));
        acc_in    = 41'(64'sd14 <<< 15);
        acc_valid = 1'b1;
        tick(1);
        acc_valid  = 1'b0;
        tick(1);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level), 4);
        chk("full_pushpop_no_drop", 32'(drop_flag), 0);
        dout_ready = 1'b1;
        tick(6);
        chk("final_level", 32'(fifo_level), 0);
        chk("final_sb_empty", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
